// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the AD7476 sample sequencer: FSM state
// encoding (also the debug-register value) and the converter frame geometry.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CONV = 2'd2,
    ST_PUSH = 2'd3
  } seq_st_e;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;

  function automatic logic [31:0] pack_pair(input logic [ADC_DATA_BITS-1:0] s1,
                                            input logic [ADC_DATA_BITS-1:0] s0);
    return {4'h0, s1, 4'h0, s0};
  endfunction

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// Control/status link between the sequencer FSM (master) and the serial
// frame shifter (slave). start/abort are single-cycle requests; done is a
// one-cycle pulse in the last CS_n-low clock; sample is stable after done.
interface adc_sample_sequencer_if;
  import adc_seq_pkg::*;

  logic                     start;
  logic                     abort;
  logic                     done;
  logic                     cs_n;
  logic                     sclk;
  logic [ADC_DATA_BITS-1:0] sample;

  modport master (output start, abort, input done, cs_n, sclk, sample);
  modport slave  (input start, abort, output done, cs_n, sclk, sample);

endinterface

// File: rtl/adc_frame_shifter.sv
// Drives one AD7476 frame: CS_n low for 16 SCLK periods (SCLK_DIV clocks low,
// then SCLK_DIV high), sampling SDATA MSB first on each SCLK rise.
module adc_frame_shifter
  import adc_seq_pkg::*;
#(
  parameter int SCLK_DIV = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   sdata_i,
  adc_sample_sequencer_if.slave  frm
);

  localparam int              PH_W     = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SCLK_DIV - 1);
  localparam logic [4:0]      BITS_ALL = 5'(ADC_FRAME_BITS);

  logic                     cs_n_q, cs_n_d;
  logic                     sclk_q, sclk_d;
  logic [PH_W-1:0]          ph_q, ph_d;
  logic [4:0]               bits_q, bits_d;
  logic [ADC_DATA_BITS-1:0] shift_q, shift_d;
  logic                     done;

  always_comb begin
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    ph_d    = ph_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    done    = !cs_n_q && sclk_q && (ph_q == PH_LAST) && (bits_q == BITS_ALL);
    if (frm.abort) begin
      cs_n_d  = 1'b1;
      sclk_d  = 1'b1;
      ph_d    = '0;
      bits_d  = '0;
      shift_d = '0;
    end else if (frm.start) begin
      cs_n_d  = 1'b0;
      sclk_d  = 1'b0;
      ph_d    = '0;
      bits_d  = '0;
      shift_d = '0;
    end else if (!cs_n_q) begin
      if (done) begin
        cs_n_d = 1'b1;
        sclk_d = 1'b1;
      end else if (ph_q == PH_LAST) begin
        ph_d   = '0;
        sclk_d = !sclk_q;
        // Rising edge: only the last 12 bits are kept, so the converter's
        // four leading zeros simply fall off the top of the register.
        if (!sclk_q) begin
          shift_d = {shift_q[ADC_DATA_BITS-2:0], sdata_i};
          bits_d  = bits_q + 5'd1;
        end
      end else begin
        ph_d = ph_q + PH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      ph_q    <= '0;
      bits_q  <= '0;
      shift_q <= '0;
    end else begin
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      ph_q    <= ph_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
    end
  end

  assign frm.done   = done;
  assign frm.cs_n   = cs_n_q;
  assign frm.sclk   = sclk_q;
  assign frm.sample = shift_q;

endmodule

// File: rtl/adc_sample_sequencer.sv
// AD7476 sample sequencer: rate timer, IDLE/WAIT/CONV/PUSH FSM, overrun flag
// and receive-FIFO writer. Define ADC_PACK_EN to pair samples per FIFO word.
module adc_sample_sequencer
  import adc_seq_pkg::*;
#(
  parameter int RATE_W   = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic              WBs_CLK_i,
  input  logic              WBs_RST_i,
  input  logic              Sensor_Enable_i,
  input  logic [RATE_W-1:0] Rate_Div_i,
  input  logic              Fifo_Full_i,
  input  logic              ADC_SDATA_i,
  output logic              ADC_CS_n_o,
  output logic              ADC_SCLK_o,
  output logic [31:0]       Sensor_RD_Data_o,
  output logic              Sensor_RD_Push_o,
  output logic              Overrun_o,
  output logic [1:0]        Seq_St_o
);

  adc_sample_sequencer_if frm ();

  adc_frame_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk_i   (WBs_CLK_i),
    .rst_i   (WBs_RST_i),
    .sdata_i (ADC_SDATA_i),
    .frm     (frm.slave)
  );

  seq_st_e           state_q, state_d;
  logic [RATE_W-1:0] timer_q, timer_d;
  logic              ovr_q, ovr_d;
  logic              push_q, push_d;
  logic [31:0]       data_q, data_d;
  logic              tick, start;
`ifdef ADC_PACK_EN
  logic [ADC_DATA_BITS-1:0] half_q, half_d;
  logic                     half_vld_q, half_vld_d;
`endif

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ovr_d   = ovr_q;
    push_d  = 1'b0;
    data_d  = data_q;
    tick    = 1'b0;
    start   = 1'b0;
`ifdef ADC_PACK_EN
    half_d     = half_q;
    half_vld_d = half_vld_q;
`endif
    if (!Sensor_Enable_i) begin
      state_d = ST_IDLE;
      ovr_d   = 1'b0;
`ifdef ADC_PACK_EN
      half_vld_d = 1'b0;
`endif
    end else if (state_q == ST_IDLE) begin
      state_d = ST_WAIT;
      timer_d = Rate_Div_i;
      ovr_d   = 1'b0;
    end else begin
      // The timer free-runs in every active state; a tick outside WAIT is a missed trigger.
      if (timer_q == '0) begin
        tick    = 1'b1;
        timer_d = Rate_Div_i;
      end else begin
        timer_d = timer_q - RATE_W'(1);
      end
      case (state_q)
        ST_WAIT: begin
          if (tick) begin
            state_d = ST_CONV;
            start   = 1'b1;
          end
        end
        ST_CONV: begin
          if (tick) ovr_d = 1'b1;
          if (frm.done) state_d = ST_PUSH;
        end
        ST_PUSH: begin
          if (tick) ovr_d = 1'b1;
          state_d = ST_WAIT;
          if (Fifo_Full_i) begin
            ovr_d = 1'b1;
`ifdef ADC_PACK_EN
            half_vld_d = 1'b0;
`endif
          end else begin
`ifdef ADC_PACK_EN
            if (half_vld_q) begin
              push_d     = 1'b1;
              data_d     = pack_pair(frm.sample, half_q);
              half_vld_d = 1'b0;
            end else begin
              half_d     = frm.sample;
              half_vld_d = 1'b1;
            end
`else
            push_d = 1'b1;
            data_d = {{(32-ADC_DATA_BITS){1'b0}}, frm.sample};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      ovr_q   <= 1'b0;
      push_q  <= 1'b0;
      data_q  <= '0;
`ifdef ADC_PACK_EN
      half_q     <= '0;
      half_vld_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ovr_q   <= ovr_d;
      push_q  <= push_d;
      data_q  <= data_d;
`ifdef ADC_PACK_EN
      half_q     <= half_d;
      half_vld_q <= half_vld_d;
`endif
    end
  end

  assign frm.start        = start;
  assign frm.abort        = !Sensor_Enable_i;
  assign ADC_CS_n_o       = frm.cs_n;
  assign ADC_SCLK_o       = frm.sclk;
  assign Sensor_RD_Data_o = data_q;
  assign Sensor_RD_Push_o = push_q;
  assign Overrun_o        = ovr_q;
  assign Seq_St_o         = state_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: randomized episodes checked cycle by cycle
// against a trigger/frame-schedule model derived from the timing rules.
module tb_adc_sample_sequencer;

  localparam int RATE_W   = 16;
  localparam int SCLK_DIV = 2;
  localparam int D        = SCLK_DIV;
  localparam int FRAME    = 32 * D;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              en, full, sdata;
  logic [RATE_W-1:0] rate;
  logic              cs_n_o, sclk_o, push_o, ovr_o;
  logic [31:0]       data_o;
  logic [1:0]        st_o;

  adc_sample_sequencer #(.RATE_W(RATE_W), .SCLK_DIV(SCLK_DIV)) dut (
    .WBs_CLK_i        (clk),
    .WBs_RST_i        (rst),
    .Sensor_Enable_i  (en),
    .Rate_Div_i       (rate),
    .Fifo_Full_i      (full),
    .ADC_SDATA_i      (sdata),
    .ADC_CS_n_o       (cs_n_o),
    .ADC_SCLK_o       (sclk_o),
    .Sensor_RD_Data_o (data_o),
    .Sensor_RD_Push_o (push_o),
    .Overrun_o        (ovr_o),
    .Seq_St_o         (st_o)
  );

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_data;
  logic [11:0] half;
  bit          half_vld;
  bit          aligned;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [5:0] exp_ctl, input logic [31:0] exp_data);
    check({tag, "_ctl"}, 64'({cs_n_o, sclk_o, push_o, ovr_o, st_o}), 64'(exp_ctl));
    check({tag, "_data"}, 64'(data_o), 64'(exp_data));
    if (push_o === 1'b1) begin
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("fifo_word", 64'(data_o), 64'(exp_q.pop_front()));
    end
  endtask

  // One enable window: cycle 0 is the enable-rise cycle, len is the cycle in
  // which enable drops (or reset hits). Frames start at the first trigger
  // seen outside a frame; a frame occupies CS_n-low cycles fs+1..fs+FRAME,
  // the PUSH slot is fs+FRAME+1 and a push is visible one cycle later.
  task automatic run_episode(input int r, input int len, input int full_pct, input bit end_rst);
    int          next_tick, fs, push_at, k;
    logic [31:0] push_word;
    logic [15:0] word;
    logic [11:0] s;
    bit          ovr, in_frame, push_slot, psh, cs_e, sclk_e;
    logic [1:0]  st_e;
    next_tick = r + 1;
    fs        = -1000000;
    push_at   = -1;
    push_word = '0;
    word      = '0;
    ovr       = 1'b0;
    rate      = RATE_W'(r);
    for (int n = 0; n <= len; n++) begin
      if (!(n == 0 && aligned)) @(negedge clk);
      aligned   = 1'b0;
      in_frame  = (n >= fs + 1) && (n <= fs + FRAME);
      push_slot = (n == fs + FRAME + 1);
      k         = n - fs - 1;
      if (n == 0) begin
        check_outputs("rise", 6'b110000, last_data);
      end else begin
        st_e   = in_frame ? 2'd2 : (push_slot ? 2'd3 : 2'd1);
        cs_e   = !in_frame;
        sclk_e = in_frame ? ((k % (2 * D)) >= D) : 1'b1;
        psh    = (n == push_at);
        if (psh) last_data = push_word;
        check_outputs("run", {cs_e, sclk_e, psh, ovr, st_e}, last_data);
      end
      if (n == len) begin
        half_vld = 1'b0;
        if (end_rst) begin
          #2 rst = 1'b1;
          #1;
          last_data = '0;
          exp_q.delete();
          check_outputs("async_rst", 6'b110000, 32'd0);
          @(negedge clk);
          rst     = 1'b0;
          aligned = 1'b1;
        end else begin
          en = 1'b0;
        end
      end else begin
        en    = 1'b1;
        full  = ($urandom_range(99) < full_pct);
        sdata = (n > 0 && in_frame) ? word[4'(15 - k / (2 * D))] : 1'($urandom_range(1));
        if (n > 0) begin
          if (n == next_tick) begin
            next_tick += r + 1;
            if (!in_frame && !push_slot) begin
              fs   = n;
              word = 16'($urandom);
            end else begin
              ovr = 1'b1;
            end
          end
          if (push_slot) begin
            s = word[11:0];
            if (full) begin
              ovr      = 1'b1;
              half_vld = 1'b0;
            end else begin
`ifdef ADC_PACK_EN
              if (half_vld) begin
                push_word = {4'h0, s, 4'h0, half};
                push_at   = n + 1;
                exp_q.push_back(push_word);
                half_vld  = 1'b0;
              end else begin
                half     = s;
                half_vld = 1'b1;
              end
`else
              push_word = {20'h0, s};
              push_at   = n + 1;
              exp_q.push_back(push_word);
`endif
            end
          end
        end
      end
    end
    if (!end_rst) begin
      @(negedge clk);
      check_outputs("disabled", 6'b110000, last_data);
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    full      = 1'b0;
    sdata     = 1'b0;
    rate      = '0;
    last_data = '0;
    half      = '0;
    half_vld  = 1'b0;
    aligned   = 1'b0;
    #2;
    check_outputs("reset", 6'b110000, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_episode(99, 500, 0, 1'b0);   // nominal rate, pushes every 100 clocks
    run_episode(40, 400, 0, 1'b0);   // trigger faster than a frame: overrun
    run_episode(99, 450, 40, 1'b0);  // FIFO full at push slots
    run_episode(99, 129, 0, 1'b0);   // disable in the middle of bit 7
    run_episode(99, 300, 0, 1'b0);   // clean frames after re-enable
    run_episode(60, 80, 0, 1'b1);    // async reset mid-CONV, enable held
    run_episode(60, 300, 0, 1'b0);   // restart straight out of reset
    run_episode(0, 200, 10, 1'b0);   // minimum period: tick every clock
    for (int i = 0; i < 6; i++) begin
      run_episode(int'($urandom_range(250)), int'($urandom_range(600, 50)),
                  int'($urandom_range(30)), ($urandom_range(3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
